// File: rtl/i2s_event_sync_if.sv
// Event-line bundle between the I2S event synchroniser and its consumer.
// The master drives the raw lines and the ack/clear requests; the slave reports events.
interface i2s_event_sync_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 4
);
  logic [NCH-1:0]       async_in;
  logic [NCH-1:0]       evt_ack;
  logic [NCH-1:0]       ovf_clr;
  logic [NCH-1:0]       evt_pulse;
  logic [NCH-1:0]       evt_pending;
  logic [NCH*CNT_W-1:0] evt_count;
  logic [NCH-1:0]       evt_ovf;

  modport master (
    output async_in, evt_ack, ovf_clr,
    input  evt_pulse, evt_pending, evt_count, evt_ovf
  );

  modport slave (
    input  async_in, evt_ack, ovf_clr,
    output evt_pulse, evt_pending, evt_count, evt_ovf
  );
endinterface

// File: rtl/i2s_event_sync.sv
// Per-channel synchroniser, edge detector and saturating pending-event counter.
// The bus interface must be instantiated with the same NCH/CNT_W as this module.
module i2s_event_sync #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter int EDGE_MODE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  i2s_event_sync_if.slave   bus
);
  localparam int                 PRIME_W   = 3;
  localparam logic [PRIME_W-1:0] PRIME_END = PRIME_W'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  logic [SYNC_STAGES-1:0][NCH-1:0] chain_q, chain_d;
  logic [NCH-1:0]                  sync_w, last_q, pulse_q;
  logic [NCH-1:0]                  raw_edge, evt_edge, ovf_set, ovf_q, ovf_d;
  logic [PRIME_W-1:0]              prime_q, prime_d;
  logic                            armed;
  logic [NCH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [NCH-1:0]                  pend_w;

  assign sync_w = chain_q[SYNC_STAGES-1];
  assign armed  = (prime_q == PRIME_END);

  always_comb begin
    chain_d    = chain_q;
    chain_d[0] = bus.async_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      chain_d[s] = chain_q[s-1];
    end
  end

  // Priming counter stops at PRIME_END; until then edges against reset-zero history are ignored.
  always_comb begin
    prime_d = armed ? prime_q : prime_q + PRIME_W'(1);
  end

  always_comb begin
    case (EDGE_MODE)
      0:       raw_edge = sync_w & ~last_q;
      1:       raw_edge = ~sync_w & last_q;
      default: raw_edge = sync_w ^ last_q;
    endcase
    evt_edge = armed ? raw_edge : '0;
  end

  // An edge and an ack in the same cycle cancel, so they can never overflow.
  always_comb begin
    cnt_d   = cnt_q;
    ovf_set = '0;
    for (int i = 0; i < NCH; i++) begin
      if (evt_edge[i] && !bus.evt_ack[i]) begin
        if (cnt_q[i] == CNT_MAX) ovf_set[i] = 1'b1;
        else                     cnt_d[i]   = cnt_q[i] + CNT_W'(1);
      end else if (!evt_edge[i] && bus.evt_ack[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
    ovf_d = ovf_set | (ovf_q & ~bus.ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_q <= '0;
      last_q  <= '0;
      prime_q <= '0;
      pulse_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= '0;
    end else begin
      chain_q <= chain_d;
      last_q  <= sync_w;
      prime_q <= prime_d;
      pulse_q <= evt_edge;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    pend_w = '0;
    for (int i = 0; i < NCH; i++) begin
      pend_w[i] = |cnt_q[i];
    end
  end

  assign bus.evt_pulse   = pulse_q;
  assign bus.evt_count   = cnt_q;
  assign bus.evt_pending = pend_w;
  assign bus.evt_ovf     = ovf_q;
endmodule
